// File: rtl/test_status_pkg.sv
// rtl/test_status_pkg.sv - shared state, reason and mode definitions for the test status monitor
package test_status_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_DONE_PASS = 2'd2,
      ST_DONE_FAIL = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      REASON_NONE      = 2'd0,
      REASON_PASS      = 2'd1,
      REASON_FAIL_CODE = 2'd2,
      REASON_TIMEOUT   = 2'd3
   } reason_t;

   localparam int MODE_ALL = 0;
   localparam int MODE_ANY = 1;

endpackage

// File: rtl/tohost_decoder.sv
// rtl/tohost_decoder.sv - latches the first pass/fail tohost write of one channel
module tohost_decoder #(
   parameter int TH_W = 64
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            clear,
   input  logic            enable,
   input  logic            valid,
   input  logic [TH_W-1:0] data,
   output logic            pass_hit,
   output logic            fail_hit,
   output logic            pass_seen,
   output logic [TH_W-2:0] fail_code
);

   logic            latched;
   logic            passed;
   logic [TH_W-2:0] code_q;
   logic            first;

   // Even values are ordinary tohost traffic and never latch the channel.
   assign first     = enable && valid && !latched;
   assign pass_hit  = first && (data == TH_W'(1));
   assign fail_hit  = first && data[0] && (data != TH_W'(1));
   assign pass_seen = passed || pass_hit;
   assign fail_code = fail_hit ? data[TH_W-1:1] : code_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         latched <= 1'b0;
         passed  <= 1'b0;
         code_q  <= '0;
      end else if (clear) begin
         latched <= 1'b0;
         passed  <= 1'b0;
         code_q  <= '0;
      end else if (pass_hit) begin
         latched <= 1'b1;
         passed  <= 1'b1;
      end else if (fail_hit) begin
         latched <= 1'b1;
         code_q  <= data[TH_W-1:1];
      end
   end

endmodule

// File: rtl/test_status_monitor.sv
// rtl/test_status_monitor.sv - run controller deciding pass/fail/timeout from per-channel tohost writes
module test_status_monitor
   import test_status_pkg::*;
#(
   parameter int  NUM_CH = 2,
   parameter int  TH_W   = 64,
   parameter int  CNT_W  = 64,
   parameter int  MODE   = MODE_ALL,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [CNT_W-1:0]       max_cycles,
   input  logic [CNT_W-1:0]       dump_start,
   input  logic [CNT_W-1:0]       dump_len,
   input  logic [NUM_CH-1:0]      th_valid,
   input  logic [NUM_CH*TH_W-1:0] th_data,
   output logic [CNT_W-1:0]       cycle_count,
   output logic                   wave_en,
   output logic                   done,
   output logic                   pass,
   output logic [1:0]             reason,
   output logic [CH_W-1:0]        fail_ch,
   output logic [TH_W-2:0]        fail_code
);

   state_t            state, next_state;
   reason_t           reason_q, reason_d;
   logic [NUM_CH-1:0] pass_hit, fail_hit, pass_seen;
   logic [TH_W-2:0]   dec_code [NUM_CH];
   logic              run, launch, timeout, pass_now, fail_any;
   logic [CH_W-1:0]   fail_idx;
   logic [TH_W-2:0]   fail_val;
   logic [CNT_W-1:0]  count_inc;
   logic [CNT_W:0]    win_end;

   assign run    = (state == ST_RUN);
   assign launch = start && !run;
   assign reason = reason_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tohost_decoder #(.TH_W(TH_W)) u_dec (
         .clock     (clock),
         .reset_n   (reset_n),
         .clear     (launch),
         .enable    (run),
         .valid     (th_valid[i]),
         .data      (th_data[i*TH_W +: TH_W]),
         .pass_hit  (pass_hit[i]),
         .fail_hit  (fail_hit[i]),
         .pass_seen (pass_seen[i]),
         .fail_code (dec_code[i])
      );
   end

   // Descending scan so the lowest failing channel is the last one assigned.
   always_comb begin
      fail_idx = '0;
      fail_val = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (fail_hit[i]) begin
            fail_idx = CH_W'(i);
            fail_val = dec_code[i];
         end
      end
   end

   assign fail_any  = |fail_hit;
   assign timeout   = (max_cycles != '0) && (cycle_count > max_cycles);
   assign pass_now  = (MODE == MODE_ANY) ? (|pass_hit) : (&pass_seen);
   assign count_inc = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
   assign win_end   = {1'b0, dump_start} + {1'b0, dump_len};

   function automatic logic in_window(input logic [CNT_W-1:0] cnt);
      return (cnt >= dump_start) && ((dump_len == '0) || ({1'b0, cnt} < win_end));
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      reason_d   = REASON_NONE;
      case (state)
         ST_RUN: begin
            if (fail_any) begin
               next_state = ST_DONE_FAIL;
               reason_d   = REASON_FAIL_CODE;
            end else if (timeout) begin
               next_state = ST_DONE_FAIL;
               reason_d   = REASON_TIMEOUT;
            end else if (pass_now) begin
               next_state = ST_DONE_PASS;
               reason_d   = REASON_PASS;
            end
         end
         default: begin
            if (start) next_state = ST_RUN;
         end
      endcase
   end

   // The counter holds on the deciding edge so it freezes at the deciding cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cycle_count <= '0;
         wave_en     <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         reason_q    <= REASON_NONE;
         fail_ch     <= '0;
         fail_code   <= '0;
      end else if (launch) begin
         cycle_count <= CNT_W'(1);
         wave_en     <= in_window(CNT_W'(1));
         done        <= 1'b0;
         pass        <= 1'b0;
         reason_q    <= REASON_NONE;
         fail_ch     <= '0;
         fail_code   <= '0;
      end else if (run) begin
         if (next_state != ST_RUN) begin
            wave_en   <= 1'b0;
            done      <= 1'b1;
            pass      <= (reason_d == REASON_PASS);
            reason_q  <= reason_d;
            fail_ch   <= (reason_d == REASON_FAIL_CODE) ? fail_idx : '0;
            fail_code <= (reason_d == REASON_FAIL_CODE) ? fail_val : '0;
         end else begin
            cycle_count <= count_inc;
            wave_en     <= in_window(count_inc);
         end
      end
   end

endmodule

// File: doc/test_status_monitor.md
TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of monitored cores/harness instances (range 1..8).
REQ-002 The block SHALL have parameter TH_W, default 64, giving the tohost word width.
REQ-003 The block SHALL have parameter CNT_W, default 64, giving the cycle counter width.
REQ-004 The block SHALL have parameter MODE, default MODE_ALL, selecting MODE_ALL (every channel must pass) or MODE_ANY (first pass ends the test).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 The block SHALL have port clock  in  1  sole clock.
REQ-007 The block SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-008 The block SHALL have port start  in  1  one-cycle pulse that begins a run.
REQ-009 The block SHALL have port max_cycles  in  CNT_W  timeout limit (0 = none).
REQ-010 The block SHALL have port dump_start  in  CNT_W  first cycle of the wave window.
REQ-011 The block SHALL have port dump_len  in  CNT_W  wave window length (0 = until done).
REQ-012 The block SHALL have port th_valid  in  NUM_CH  per-channel tohost write strobe.
REQ-013 The block SHALL have port th_data  in  NUM_CH*TH_W  per-channel tohost value, channel i at bits [i*TH_W +: TH_W].
REQ-014 The block SHALL have port cycle_count  out  CNT_W  run cycle counter.
REQ-015 The block SHALL have port wave_en  out  1  waveform dump enable.
REQ-016 The block SHALL have port done  out  1  sticky test-complete flag.
REQ-017 The block SHALL have port pass  out  1  sticky result, valid when done=1.
REQ-018 The block SHALL have port reason  out  2  completion reason code.
REQ-019 The block SHALL have port fail_ch  out  max(1,$clog2(NUM_CH))  index of the failing channel.
REQ-020 The block SHALL have port fail_code  out  TH_W-1  value th_data>>1 of the failing channel.

Function
REQ-021 The FSM SHALL have states IDLE, RUN, DONE_PASS and DONE_FAIL; reset SHALL place it in IDLE.
REQ-022 On start in IDLE or a DONE state, the FSM SHALL enter RUN on the next cycle and clear cycle_count, per-channel status and every result output.
REQ-023 start SHALL be ignored while in RUN.
REQ-024 cycle_count SHALL read 1 in the first RUN cycle, increment every RUN cycle, saturate at all-ones and freeze in the DONE states.
REQ-025 Channel decode SHALL apply only in RUN, only to the first strobe per channel, with later strobes ignored: th_data==1 is a pass; odd th_data >1 is a fail with code th_data>>1; even th_data is ignored and does not latch the channel.
REQ-026 A timeout SHALL occur when max_cycles!=0 and cycle_count>max_cycles.
REQ-027 Same-cycle events SHALL resolve with priority channel fail > timeout > pass; among simultaneous failures, the lowest channel index SHALL win.
REQ-028 Pass SHALL be declared in MODE_ALL when every channel has latched pass (including strobes in the current cycle), and in MODE_ANY on the first pass.
REQ-029 done, pass, reason, fail_ch and fail_code SHALL be registered and asserted the cycle after the deciding edge (1-cycle latency), and SHALL hold until reset or the next start.
REQ-030 reason encoding SHALL be 0 NONE, 1 PASS, 2 FAIL_CODE, 3 TIMEOUT; fail_ch and fail_code SHALL be 0 unless reason=2.
REQ-031 wave_en SHALL be registered: 1 in RUN when cycle_count>=dump_start and (dump_len==0 or cycle_count<dump_start+dump_len, with the sum computed in CNT_W+1 bits); 0 in IDLE and DONE.

Reset
REQ-032 Asserting reset_n low at any time, including mid-run, SHALL asynchronously force IDLE, all outputs to 0 and all per-channel status to cleared.
REQ-033 Deassertion of reset_n SHALL be synchronised externally; the block SHALL take no action before the first start.

Structure
REQ-034 Package test_status_pkg SHALL hold the FSM state enum, the reason enum, and the MODE_ALL/MODE_ANY constants.
REQ-035 Sub-module tohost_decoder SHALL be instantiated NUM_CH times, each latching pass/fail/code for one channel.

Verification
REQ-036 With NUM_CH=2 and MODE_ALL, ch0 writing 1 at cycle 10 and ch1 writing 1 at cycle 20 SHALL give done=1, pass=1, reason=1 at cycle 21 and cycle_count frozen at 20.
REQ-037 With NUM_CH=2, ch1 writing 0x7 at cycle 5 SHALL give done=1, pass=0, reason=2, fail_ch=1, fail_code=3.
REQ-038 With max_cycles=100 and no writes, the bench SHALL see done at cycle_count=101 with reason=3; in the same cycle, a ch0 write of 0x5 SHALL yield reason=2 instead.
REQ-039 With dump_start=3 and dump_len=4, wave_en SHALL be high for exactly cycle_count 3..6; with dump_len=0, it SHALL stay high until done.
REQ-040 With MODE_ANY, ch0 writing 1 at cycle 8 SHALL give pass; reset_n pulsed low at cycle 4 of a later run SHALL force all outputs to 0 immediately; a subsequent start SHALL restart cycle_count from 1.
